// File: rtl/sym_packer_if.sv
// rtl/sym_packer_if.sv - bit-stream input and symbol output signals of the symbol packer
interface sym_packer_if;
  logic [1:0] sel;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [3:0] sym_out;
  logic [1:0] sel_out;
  logic       sym_stb;
  logic       underrun;

  modport master (
    output sel, bit_in, bit_valid,
    input  bit_ready, sym_out, sel_out, sym_stb, underrun
  );

  modport slave (
    input  sel, bit_in, bit_valid,
    output bit_ready, sym_out, sel_out, sym_stb, underrun
  );
endinterface

// File: rtl/sym_packer.sv
// rtl/sym_packer.sv - serial bit to modulation-symbol packer with a one-symbol holding buffer
// Optional additive x^7+x^4+1 scrambler on accepted bits: define SYM_PACKER_SCRAMBLE_EN.
module sym_packer #(
  parameter int SYM_DIV = 8,
  parameter int CNT_W   = 8
) (
  input logic         clk,
  input logic         rst_n,
  sym_packer_if.slave sp
);
  logic [1:0]       sel_q;
  logic [3:0]       asm_word;
  logic [2:0]       asm_cnt;
  logic [3:0]       hold_word;
  logic [1:0]       hold_sel;
  logic             hold_vld;
  logic [CNT_W-1:0] timer;
  logic             live;
  logic [3:0]       sym_q;
  logic [1:0]       sel_out_q;
  logic             stb_q;
  logic             und_q;

  logic [2:0] k;
  logic       full;
  logic       boundary;
  logic       accept;
  logic       sel_chg;
  logic       xfer;
  logic       pbit;

  assign k        = {1'b0, sel_q} + 3'd1;
  assign full     = (asm_cnt == k);
  assign boundary = (timer == CNT_W'(SYM_DIV - 1));
  // live keeps bit_ready low on the first cycle after reset without a combinational path from rst_n
  assign sp.bit_ready = live && !(full && hold_vld);
  assign accept   = sp.bit_valid && sp.bit_ready;
  assign sel_chg  = (sp.sel != sel_q);
  // a holding slot being emitted at this boundary can be refilled on the same edge
  assign xfer     = full && (!hold_vld || boundary) && !sel_chg;

`ifdef SYM_PACKER_SCRAMBLE_EN
  logic [6:0] lfsr;
  logic       ks;

  assign ks   = lfsr[6] ^ lfsr[3];
  assign pbit = sp.bit_in ^ ks;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= 7'h7F;
    end else if (accept) begin
      lfsr <= {lfsr[5:0], ks};
    end
  end
`else
  assign pbit = sp.bit_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q     <= sp.sel;
      asm_word  <= '0;
      asm_cnt   <= '0;
      hold_word <= '0;
      hold_sel  <= '0;
      hold_vld  <= 1'b0;
      timer     <= '0;
      live      <= 1'b0;
      sym_q     <= '0;
      sel_out_q <= '0;
      stb_q     <= 1'b0;
      und_q     <= 1'b0;
    end else begin
      live  <= 1'b1;
      sel_q <= sp.sel;
      timer <= boundary ? '0 : timer + 1'b1;
      stb_q <= boundary && hold_vld;
      und_q <= boundary && !hold_vld;

      if (boundary) begin
        if (hold_vld) begin
          sym_q     <= hold_word;
          sel_out_q <= hold_sel;
        end else begin
          sym_q <= '0;
        end
      end

      // a select change drops the assembly, including a bit accepted on that edge
      if (sel_chg) begin
        asm_word <= '0;
        asm_cnt  <= '0;
      end else if (xfer) begin
        asm_word <= {3'b000, pbit & accept};
        asm_cnt  <= {2'b00, accept};
      end else if (accept) begin
        asm_word <= {asm_word[2:0], pbit};
        asm_cnt  <= asm_cnt + 3'd1;
      end

      if (xfer) begin
        hold_word <= asm_word;
        hold_sel  <= sel_q;
        hold_vld  <= 1'b1;
      end else if (boundary) begin
        hold_vld <= 1'b0;
      end
    end
  end

  assign sp.sym_out  = sym_q;
  assign sp.sel_out  = sel_out_q;
  assign sp.sym_stb  = stb_q;
  assign sp.underrun = und_q;
endmodule
